slow_clk_monitor: RTL and testbench
===================================

SLOW_CLK_MONITOR -- requirements
Module: slow_clk_monitor

Interface
REQ-001 SHALL have parameter CNT_W, default 28, width of the period counter and period output.
REQ-002 SHALL have parameter TIMEOUT, default 120000000, fast cycles without a rising edge before the input is declared lost; legal range 4..2^CNT_W-1.
REQ-003 SHALL have port CLKFast  input  1  single 100 MHz clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port slowClkIn  input  1  divided clock under test, asynchronous to CLKFast.
REQ-006 SHALL have port risePulse  output  1  one-cycle pulse per synchronized rising edge.
REQ-007 SHALL have port fallPulse  output  1  one-cycle pulse per synchronized falling edge.
REQ-008 SHALL have port period  output  CNT_W  CLKFast cycles between the last two rising edges.
REQ-009 SHALL have port periodValid  output  1  one-cycle pulse when period updates.
REQ-010 SHALL have port locked  output  1  high while state is RUN.
REQ-011 SHALL have port lost  output  1  high while state is LOST.

Function
REQ-012 SHALL pass slowClkIn through two synchronizer flops (s1, s2) and one history flop (s3).
REQ-013 SHALL drive risePulse = s2 & ~s3 and fallPulse = ~s2 & s3 as registered outputs; input edge to pulse latency is 3 CLKFast cycles.
REQ-014 SHALL keep counter cnt (CNT_W bits): on a risePulse cycle cnt <= 0, else cnt <= cnt+1, holding (no wrap) once cnt = TIMEOUT-1.
REQ-015 SHALL implement states IDLE, ARMED, RUN, LOST; IDLE after reset.
REQ-016 IDLE: risePulse -> ARMED, no periodValid; cnt = TIMEOUT-1 -> LOST.
REQ-017 ARMED: risePulse -> RUN, period <= cnt+1, periodValid pulses; cnt = TIMEOUT-1 -> LOST.
REQ-018 RUN: risePulse -> RUN, period <= cnt+1, periodValid pulses; cnt = TIMEOUT-1 -> LOST.
REQ-019 LOST: risePulse -> ARMED, period unchanged, no periodValid; otherwise stay.
REQ-020 SHALL give risePulse priority when risePulse and cnt = TIMEOUT-1 coincide (no LOST entry).
REQ-021 SHALL assert periodValid in the cycle after the risePulse that captured period, coincident with the new period value.
REQ-022 SHALL hold period between updates, including through LOST.
REQ-023 SHALL register locked and lost from the next-state value so they change in the same cycle as the state.
REQ-024 fallPulse SHALL have no effect on state, cnt or period.

Reset
REQ-025 rst high SHALL immediately force s1, s2, s3, cnt, period to 0, state to IDLE, and risePulse, fallPulse, periodValid, locked, lost to 0.
REQ-026 rst asserted mid-measurement SHALL discard the partial count; first rising edge after release enters ARMED without a periodValid.
REQ-027 synchronizer SHALL resample slowClkIn after release; a slowClkIn already high at release SHALL produce one risePulse 3 cycles later.

Verification (bench uses TIMEOUT=64)
REQ-028 slowClkIn toggling every 2 cycles (period 4) -> first periodValid after 2nd rise with period=4, locked=1, then periodValid every 4 cycles, fallPulse 2 cycles after each risePulse.
REQ-029 slowClkIn period 10 for 5 cycles, then switched to period 20 -> period reports 10 until the first full 20-cycle interval, then 20; locked stays 1.
REQ-030 slowClkIn held low after locking -> lost=1, locked=0 exactly 64 cycles after the last risePulse; next rise -> ARMED (lost=0, locked=0), following rise -> RUN with correct period.
REQ-031 rise arriving on the cycle cnt=63 -> no LOST, period=64, periodValid pulses.
REQ-032 rst pulsed asynchronously (mid-cycle) during RUN -> all outputs 0 immediately; two rises after release needed for locked=1.
REQ-033 slowClkIn constant high from reset -> one risePulse, no fallPulse, LOST 64 cycles later, period stays 0.

Source files
------------

// File: rtl/slow_clk_monitor.sv
// slow_clk_monitor
// Watches a slow divided clock from the fast clock domain. The input is
// synchronized and edge-detected. The module measures the rising-edge period
// in CLKFast cycles and tracks lock. It declares the input lost when no rising
// edge arrives for TIMEOUT cycles.
module slow_clk_monitor #(
  parameter int CNT_W   = 28,
  parameter int TIMEOUT = 120000000
) (
  input  logic             CLKFast,
  input  logic             rst,
  input  logic             slowClkIn,
  output logic             risePulse,
  output logic             fallPulse,
  output logic [CNT_W-1:0] period,
  output logic             periodValid,
  output logic             locked,
  output logic             lost
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ARMED = 2'd1;
  localparam logic [1:0] RUN   = 2'd2;
  localparam logic [1:0] LOST  = 2'd3;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             s1;
  logic             s2;
  logic             s3;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       state;
  logic [1:0]       state_next;
  logic             capture;
  logic             timeout;

  // Two-flop synchronizer followed by a history flop for edge detection
  always_ff @(posedge CLKFast or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= slowClkIn;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Registered edge pulses, three cycles after the input edge
  always_ff @(posedge CLKFast or posedge rst) begin
    if (rst) begin
      risePulse <= 1'b0;
      fallPulse <= 1'b0;
    end else begin
      risePulse <= s2 & ~s3;
      fallPulse <= ~s2 & s3;
    end
  end

  // Cycles since the last rising edge; saturates at TIMEOUT-1 so it never wraps
  always_ff @(posedge CLKFast or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (risePulse) begin
      cnt <= '0;
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + CNT_ONE;
    end
  end

  assign timeout = (cnt == CNT_MAX);

  // Next-state logic; a rising edge always wins over a coincident timeout
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (risePulse) begin
          state_next = ARMED;
        end else if (timeout) begin
          state_next = LOST;
        end
      end
      ARMED, RUN: begin
        if (risePulse) begin
          state_next = RUN;
          capture    = 1'b1;
        end else if (timeout) begin
          state_next = LOST;
        end
      end
      LOST: begin
        if (risePulse) begin
          state_next = ARMED;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State, period capture and status flags taken from the next state
  always_ff @(posedge CLKFast or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      period      <= '0;
      periodValid <= 1'b0;
      locked      <= 1'b0;
      lost        <= 1'b0;
    end else begin
      state       <= state_next;
      periodValid <= capture;
      if (capture) begin
        period <= cnt + CNT_ONE;
      end
      locked <= (state_next == RUN);
      lost   <= (state_next == LOST);
    end
  end

endmodule

// File: tb/tb_slow_clk_monitor.sv
// Testbench for slow_clk_monitor with TIMEOUT=64.
// The reference model works from the sampled input history. It places a rise
// pulse two samples after the input went high. It measures periods as the
// distance between rise-pulse cycles and counts the rises seen since
// reset/loss. A compare process checks every output on every cycle.
module tb_slow_clk_monitor;

  localparam int CNT_W   = 28;
  localparam int TIMEOUT = 64;

  logic             clk;
  logic             rst;
  logic             slow;
  logic             rise_pulse;
  logic             fall_pulse;
  logic [CNT_W-1:0] period;
  logic             period_valid;
  logic             locked;
  logic             lost;

  int tests  = 0;
  int failed = 0;

  slow_clk_monitor #(
    .CNT_W  (CNT_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .CLKFast    (clk),
    .rst        (rst),
    .slowClkIn  (slow),
    .risePulse  (rise_pulse),
    .fallPulse  (fall_pulse),
    .period     (period),
    .periodValid(period_valid),
    .locked     (locked),
    .lost       (lost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit               in_hist [int];
  int               k;          // edge index since reset release
  int               prev;       // edge index of the last rise pulse
  int               nrise;      // rises seen since reset or loss
  bit               m_lost;
  logic [CNT_W-1:0] m_period;
  bit               e_rise, e_fall, e_valid;

  // statistics used by the literal checks
  int edge_no = 0;
  int last_rise_edge = 0;
  int lost_edge = 0;
  int rise_cnt = 0;
  int fall_cnt = 0;
  bit lost_d = 0;

  function automatic bit get_in(input int j);
    if (j < 0) return 1'b0;
    return in_hist[j];
  endfunction

  function automatic bit rise_at(input int j);
    return get_in(j - 2) & ~get_in(j - 3);
  endfunction

  // Model update per edge, then compare #1 after the edge
  always @(posedge clk) begin
    if (rst) begin
      in_hist.delete();
      k        = 0;
      prev     = -2;   // reset counter value 0 corresponds to a virtual rise two edges back
      nrise    = 0;
      m_lost   = 0;
      m_period = '0;
      e_rise   = 0;
      e_fall   = 0;
      e_valid  = 0;
    end else begin
      in_hist[k] = slow;
      e_rise  = rise_at(k);
      e_fall  = ~get_in(k - 2) & get_in(k - 3);
      e_valid = 0;
      if (rise_at(k - 1)) begin
        if (m_lost) begin
          m_lost = 0;
          nrise  = 1;
        end else begin
          nrise++;
          if (nrise >= 2) begin
            m_period = CNT_W'((k - 1) - prev);
            e_valid  = 1;
          end
        end
        prev = k - 1;
      end else if (!m_lost && (k - prev >= TIMEOUT + 1)) begin
        m_lost = 1;
        nrise  = 0;
      end
      k++;
    end
    edge_no++;
    #1;
    chk("risePulse",   {31'd0, rise_pulse},   {31'd0, e_rise});
    chk("fallPulse",   {31'd0, fall_pulse},   {31'd0, e_fall});
    chk("periodValid", {31'd0, period_valid}, {31'd0, e_valid});
    chk("period",      {4'd0, period},        {4'd0, m_period});
    chk("locked",      {31'd0, locked},       {31'd0, (!m_lost && nrise >= 2)});
    chk("lost",        {31'd0, lost},         {31'd0, m_lost});
    if (rise_pulse === 1'b1) begin
      last_rise_edge = edge_no;
      rise_cnt++;
    end
    if (fall_pulse === 1'b1) fall_cnt++;
    if (lost === 1'b1 && !lost_d) lost_edge = edge_no;
    lost_d = (lost === 1'b1);
  end

  // ---------------- stimulus ----------------
  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic run_period(input int p, input int n);
    for (int i = 0; i < n; i++) begin
      slow = 1'b1;
      wait_cycles(p / 2);
      slow = 1'b0;
      wait_cycles(p - p / 2);
    end
  endtask

  initial begin
    int release_edge;
    int waited;
    rst  = 1'b1;
    slow = 1'b0;
    wait_cycles(3);
    chk("reset_period", {4'd0, period}, 32'd0);
    chk("reset_locked", {31'd0, locked}, 32'd0);
    chk("reset_lost",   {31'd0, lost}, 32'd0);
    rst = 1'b0;
    $display("[TB] reset released");

    // period 4: locks with period 4
    run_period(4, 8);
    chk("p4_period", {4'd0, period}, 32'd4);
    chk("p4_locked", {31'd0, locked}, 32'd1);
    $display("[TB] period-4 run done, period=%0d locked=%0b", period, locked);

    // period 10 then 20: locked throughout, final period 20
    run_period(10, 5);
    chk("p10_period", {4'd0, period}, 32'd10);
    run_period(20, 4);
    chk("p20_period", {4'd0, period}, 32'd20);
    chk("p20_locked", {31'd0, locked}, 32'd1);
    $display("[TB] period 10->20 run done, period=%0d", period);

    // hold low: lost rises after 64 full cycles following the risePulse cycle
    waited = 0;
    while (lost !== 1'b1 && waited < 200) begin
      wait_cycles(1);
      waited++;
    end
    chk("lost_seen", {31'd0, lost}, 32'd1);
    chk("lost_latency", lost_edge - last_rise_edge, 32'd65);
    chk("lost_unlocked", {31'd0, locked}, 32'd0);
    chk("lost_period_held", {4'd0, period}, 32'd20);
    $display("[TB] timeout: lost after %0d edges", lost_edge - last_rise_edge);

    run_period(10, 1);
    chk("rearm_lost", {31'd0, lost}, 32'd0);
    chk("rearm_locked", {31'd0, locked}, 32'd0);
    run_period(10, 1);
    chk("relock_locked", {31'd0, locked}, 32'd1);
    chk("relock_period", {4'd0, period}, 32'd10);
    $display("[TB] relock done, period=%0d", period);

    // rise on the last counter value: period 64, no loss
    slow = 1'b1;
    wait_cycles(5);
    slow = 1'b0;
    wait_cycles(59);
    slow = 1'b1;
    wait_cycles(6);
    chk("edge64_period", {4'd0, period}, 32'd64);
    chk("edge64_lost", {31'd0, lost}, 32'd0);
    chk("edge64_locked", {31'd0, locked}, 32'd1);
    slow = 1'b0;
    wait_cycles(5);
    $display("[TB] boundary rise done, period=%0d lost=%0b", period, lost);

    // asynchronous reset in RUN
    run_period(10, 3);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("areset_rise",   {31'd0, rise_pulse}, 32'd0);
    chk("areset_fall",   {31'd0, fall_pulse}, 32'd0);
    chk("areset_valid",  {31'd0, period_valid}, 32'd0);
    chk("areset_period", {4'd0, period}, 32'd0);
    chk("areset_locked", {31'd0, locked}, 32'd0);
    chk("areset_lost",   {31'd0, lost}, 32'd0);
    wait_cycles(2);
    rst = 1'b0;
    run_period(10, 1);
    chk("areset_armed", {31'd0, locked}, 32'd0);
    run_period(10, 1);
    chk("areset_relock", {31'd0, locked}, 32'd1);
    chk("areset_period10", {4'd0, period}, 32'd10);
    $display("[TB] async reset done, locked=%0b", locked);

    // input high at release: one rise, no fall, lost later, period 0
    rst  = 1'b1;
    slow = 1'b1;
    wait_cycles(3);
    rst = 1'b0;
    release_edge = edge_no;
    rise_cnt = 0;
    fall_cnt = 0;
    wait_cycles(100);
    chk("high_rise_cnt", rise_cnt, 32'd1);
    chk("high_fall_cnt", fall_cnt, 32'd0);
    chk("high_rise_latency", last_rise_edge - release_edge, 32'd3);
    chk("high_lost", {31'd0, lost}, 32'd1);
    chk("high_lost_latency", lost_edge - last_rise_edge, 32'd65);
    chk("high_period", {4'd0, period}, 32'd0);
    $display("[TB] constant-high run done, rises=%0d falls=%0d", rise_cnt, fall_cnt);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
